// File: rtl/cmp_pkg.sv
// Shared constants for the serial magnitude comparator resolver.
// FSM state codes, {gt,eq,lt} result encodings and a one-hot helper.
package cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == CMP_GT) || (v == CMP_EQ) || (v == CMP_LT);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Up-counter of consumed bits with clear, enable and terminal-count flag.
// tc is high while the next enabled edge would consume bit WIDTH.
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/serial_compare_resolver.sv
// Resolves MSB-first per-bit {gt,eq,lt} flags into a registered
// magnitude result with a one-cycle done pulse and sticky error flag.
module serial_compare_resolver
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic x_in,
  input  logic y_in,
  input  logic z_in,
  output logic busy,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b,
  output logic err
);

  logic [1:0] state;
  logic       decided;
  logic [2:0] triple;
  logic       accept;
  logic       consume;
  logic       last;
  logic       hit;
  logic       finish;

  assign triple  = {x_in, y_in, z_in};
  assign accept  = start && (state == S_IDLE || state == S_DONE);
  assign consume = (state == S_RUN) && bit_valid;
  assign hit     = !decided && one_hot3(triple) && !y_in;
  assign finish  = consume && (last || (EARLY_EXIT && hit));

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (consume),
    .tc (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      decided <= 1'b0;
      err     <= 1'b0;
      {a_gt_b, a_eq_b, a_lt_b} <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            decided <= 1'b0;
            err     <= 1'b0;
            {a_gt_b, a_eq_b, a_lt_b} <= CMP_EQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (consume) begin
            if (!one_hot3(triple)) err <= 1'b1;
            // only the most significant differing bit decides
            if (hit) begin
              decided <= 1'b1;
              {a_gt_b, a_eq_b, a_lt_b} <= triple;
            end
            if (finish) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_resolver.sv
// Directed bench: full-length and early-exit resolvers share stimulus.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serial_compare_resolver;

  logic clk = 1'b0;
  logic rst, start, bit_valid, x_in, y_in, z_in;
  logic busy, done, a_gt_b, a_eq_b, a_lt_b, err;
  logic e_busy, e_done, e_gt, e_eq, e_lt, e_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_compare_resolver #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
    .a_lt_b(a_lt_b), .err(err)
  );

  serial_compare_resolver #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(e_busy), .done(e_done), .a_gt_b(e_gt), .a_eq_b(e_eq),
    .a_lt_b(e_lt), .err(e_err)
  );

  // observed vector order: {busy, done, gt, eq, lt, err}
  task automatic chk(input string tag, input logic [5:0] obs,
                     input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic [2:0] t);
    bit_valid = 1'b1;
    {x_in, y_in, z_in} = t;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    bit_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    step();
  endtask

  logic [2:0] seq4 [8];

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0;
    {x_in, y_in, z_in} = 3'b000;
    step();
    step();
    chk("reset_full", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b000000);
    chk("reset_early", {e_busy, e_done, e_gt, e_eq, e_lt, e_err}, 6'b000000);
    rst = 1'b0;
    step();

    // equal operands
    pulse_start();
    chk("eq_start", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b100100);
    for (int i = 0; i < 7; i++) bit_in(3'b010);
    chk("eq_bit7", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b100100);
    bit_in(3'b010);
    chk("eq_done", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b010100);
    idle();
    chk("eq_hold", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b000100);

    // GT at the MSB, later LT bits ignored
    pulse_start();
    bit_in(3'b100);
    chk("gt_early", {e_busy, e_done, e_gt, e_eq, e_lt, e_err}, 6'b011000);
    for (int i = 0; i < 6; i++) bit_in(3'b001);
    chk("gt_bit7", {busy, done}, 2'b10);
    bit_in(3'b001);
    chk("gt_done", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b011000);
    idle();

    // LT at bit 3, early exit on the 6th cycle
    pulse_start();
    for (int i = 0; i < 4; i++) bit_in(3'b010);
    chk("lt_early_run", {e_busy, e_done}, 2'b10);
    bit_in(3'b001);
    chk("lt_early_done", {e_busy, e_done, e_gt, e_eq, e_lt, e_err}, 6'b010010);
    chk("lt_full_run", {busy, done}, 2'b10);
    bit_in(3'b010);
    chk("lt_early_after", {e_busy, e_done, e_gt, e_eq, e_lt, e_err}, 6'b000010);
    bit_in(3'b010);
    bit_in(3'b010);
    chk("lt_full_done", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b010010);
    idle();

    // stalls on every other cycle, one illegal triple
    seq4[0] = 3'b010; seq4[1] = 3'b110; seq4[2] = 3'b001; seq4[3] = 3'b100;
    seq4[4] = 3'b100; seq4[5] = 3'b100; seq4[6] = 3'b100; seq4[7] = 3'b100;
    pulse_start();
    chk("err_cleared", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b100100);
    for (int i = 0; i < 8; i++) begin
      bit_in(seq4[i]);
      if (i == 1)
        chk("err_sticky", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b100101);
      if (i < 7) begin
        bit_valid = 1'b0;
        {x_in, y_in, z_in} = 3'b111;
        step();
      end
      if (i == 6) chk("stall_run", {busy, done}, 2'b10);
    end
    chk("stall_done", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b010011);
    idle();

    // asynchronous reset mid-run
    pulse_start();
    for (int i = 0; i < 4; i++) bit_in(3'b010);
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_full", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b000000);
    chk("async_rst_early", {e_busy, e_done, e_gt, e_eq, e_lt, e_err}, 6'b000000);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b000000);

    // clean EQ after reset
    pulse_start();
    for (int i = 0; i < 8; i++) bit_in(3'b010);
    chk("restart_eq", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b010100);

    // start in DONE with a valid bit: straight to RUN, bit not consumed
    start = 1'b1;
    bit_valid = 1'b1;
    {x_in, y_in, z_in} = 3'b001;
    step();
    start = 1'b0;
    chk("done_restart", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b100100);
    bit_in(3'b100);
    for (int i = 0; i < 6; i++) bit_in(3'b010);
    chk("restart_bit7", {busy, done}, 2'b10);
    bit_in(3'b010);
    chk("restart_gt", {busy, done, a_gt_b, a_eq_b, a_lt_b, err}, 6'b011000);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
